op_decoder: RTL and testbench
=============================

Name: op_decoder

Overview:
- Host-to-device counterpart of the packet encoder.
- Deserialises 40-bit packets arriving MSB-first from the host-side bit receiver and decodes the op byte.
- Presents results as registered command pulses and state registers: audio sample words, audio start/stop, keyboard poll, LED/power requests.
- Sits between the bit-level line receiver and the audio FIFO / keyboard controller.

Parameters:
FRAME_BITS, 40, bits per packet; fixed by protocol, counter sized from it
OP_AUDIO_SAMPLE, 8'h07, op byte for a stereo audio sample packet
OP_AUDIO_CTRL, 8'hC7, op byte for audio start/stop packet
OP_KBD, 8'hC5, op byte for keyboard/LED/power packets

Ports:
clk  in  1  system clock
n_reset  in  1  asynchronous active-low reset
in_frame_start  in  1  one-cycle pulse: next in_bit_valid is bit 39 of a new packet
in_bit  in  1  serial data bit
in_bit_valid  in  1  one-cycle strobe qualifying in_bit
audio_sample  out  32  {left[15:0], right[15:0]} of last sample packet
audio_sample_valid  out  1  one-cycle pulse, audio_sample updated
audio_enabled  out  1  audio stream state (level)
audio_mode  out  8  mode byte from last audio-ctrl packet
kbd_query  out  1  one-cycle pulse: host polls keyboard
led_state  out  2  keyboard LED bits (level)
power_request  out  1  one-cycle pulse: host power-off/on request
unknown_op  out  1  one-cycle pulse: complete packet with unrecognised op
frame_error  out  1  one-cycle pulse: truncated or overlong packet

Behaviour:
- Asynchronous reset (n_reset low): all outputs 0; shift register 0; bit counter 0; FSM to IDLE.
- FSM states: IDLE, SHIFT, DECODE, DISCARD.
- IDLE: in_bit_valid ignored. in_frame_start -> SHIFT, counter cleared.
- SHIFT: each in_bit_valid shifts in_bit into bit 0 of a 40-bit register (MSB first) and increments the counter. After the 40th bit -> DECODE.
- in_frame_start in SHIFT before 40 bits: frame_error pulse, packet dropped, counter cleared, stay in SHIFT (new frame begins).
- If in_frame_start and in_bit_valid occur in the same cycle, the start takes effect first; that bit is bit 39 of the new frame.
- DECODE lasts exactly one cycle, then returns to IDLE. Outputs are registered, so pulses assert the cycle after DECODE: latency from the 40th bit strobe to a pulse is 2 clocks.
- Decode of op byte = data[39:32]:
  - OP_AUDIO_SAMPLE: audio_sample <= data[31:0]; audio_sample_valid pulse. Not gated by audio_enabled.
  - OP_AUDIO_CTRL: audio_mode <= data[31:24]; audio_enabled <= data[31:24] != 0.
  - OP_KBD:
    - data[31:24] == 8'hEF: kbd_query pulse.
    - data[31:24] == 8'h00: led_state <= data[17:16].
    - data[31:24] == 8'hC0: power_request pulse.
    - any other sub-op: unknown_op pulse.
  - Any other op byte: unknown_op pulse.
- At most one of audio_sample_valid, kbd_query, power_request, unknown_op, frame_error is asserted per cycle. Exception: frame_error may coincide with a pulse from the previous frame's DECODE; both are reported.
- Overlong frame: in_bit_valid while in DECODE or IDLE without a preceding start is ignored in IDLE. In DECODE it produces a frame_error pulse and the FSM enters DISCARD, but the already-decoded result is still issued. DISCARD ignores bits until in_frame_start.
- Level outputs (audio_enabled, audio_mode, led_state, audio_sample) hold until overwritten or reset.
- Gaps of any length between in_bit_valid strobes are legal; no timeout.

Test Plan:
- Reset then start + 40 bits of 40'h07_1234_ABCD -> audio_sample=32'h1234ABCD, audio_sample_valid high exactly one cycle, 2 clocks after the last bit strobe.
- Packet 40'hC7_01_000000, then 40'hC7_00_000000 -> audio_enabled 1, audio_mode 8'h01; then audio_enabled 0, audio_mode 8'h00.
- 40'hC5_EF_000000 -> kbd_query one pulse. 40'hC5_00_030000 -> led_state=2'b11, no pulse. 40'hC5_C0_000000 -> power_request pulse.
- Start + 20 bits, then new start + full 40'h07_00000001 -> frame_error pulse at the second start; subsequent audio_sample=32'h00000001 valid.
- Full packet 40'h55_00000000 followed by extra bit without start -> unknown_op pulse and frame_error pulse; further bits ignored until next start.
- n_reset asserted mid-packet after 30 bits, led_state previously 2'b01 -> all outputs 0 immediately; next full packet decodes correctly.

Source files
------------

// File: rtl/op_decoder.sv
// Host-to-device packet decoder: deserialises 40-bit MSB-first packets and turns
// the op byte into registered command pulses and held state registers.
//
// state   | meaning
// IDLE    | waiting for in_frame_start; stray bits ignored
// SHIFT   | collecting packet bits into the shift register
// DECODE  | one cycle: full packet present, decode op byte
// DISCARD | overlong packet seen; ignore bits until next start
module op_decoder #(
  parameter int          FRAME_BITS      = 40,
  parameter logic [7:0]  OP_AUDIO_SAMPLE = 8'h07,
  parameter logic [7:0]  OP_AUDIO_CTRL   = 8'hC7,
  parameter logic [7:0]  OP_KBD          = 8'hC5
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        in_frame_start,
  input  logic        in_bit,
  input  logic        in_bit_valid,
  output logic [31:0] audio_sample,
  output logic        audio_sample_valid,
  output logic        audio_enabled,
  output logic [7:0]  audio_mode,
  output logic        kbd_query,
  output logic [1:0]  led_state,
  output logic        power_request,
  output logic        unknown_op,
  output logic        frame_error
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE, DISCARD} state_t;

  state_t                 state_q, state_nxt;
  logic [CW-1:0]          cnt_q, cnt_nxt;
  logic [FRAME_BITS-1:0]  shift_q, shift_nxt;

  logic [31:0] sample_nxt;
  logic [7:0]  mode_nxt;
  logic        enabled_nxt;
  logic [1:0]  led_nxt;
  logic        sample_valid_nxt, kbd_query_nxt, power_nxt, unknown_nxt, ferr_nxt;
  logic        begin_frame, take_bit;
  logic [7:0]  op_byte, sub_op;

  assign op_byte = shift_q[FRAME_BITS-1 -: 8];
  assign sub_op  = shift_q[FRAME_BITS-9 -: 8];

  always_comb begin
    state_nxt        = state_q;
    cnt_nxt          = cnt_q;
    shift_nxt        = shift_q;
    sample_nxt       = audio_sample;
    mode_nxt         = audio_mode;
    enabled_nxt      = audio_enabled;
    led_nxt          = led_state;
    sample_valid_nxt = 1'b0;
    kbd_query_nxt    = 1'b0;
    power_nxt        = 1'b0;
    unknown_nxt      = 1'b0;
    ferr_nxt         = 1'b0;
    begin_frame      = 1'b0;
    take_bit         = 1'b0;

    case (state_q)
      IDLE: begin
        begin_frame = in_frame_start;
      end
      SHIFT: begin
        if (in_frame_start) begin
          begin_frame = 1'b1;
          ferr_nxt    = 1'b1;
        end else if (in_bit_valid) begin
          take_bit = 1'b1;
          if (cnt_q == LAST_BIT) state_nxt = DECODE;
        end
      end
      DECODE: begin
        state_nxt = IDLE;
        case (op_byte)
          OP_AUDIO_SAMPLE: begin
            sample_nxt       = shift_q[31:0];
            sample_valid_nxt = 1'b1;
          end
          OP_AUDIO_CTRL: begin
            mode_nxt    = sub_op;
            enabled_nxt = (sub_op != 8'h00);
          end
          OP_KBD: begin
            case (sub_op)
              8'hEF:   kbd_query_nxt = 1'b1;
              8'h00:   led_nxt       = shift_q[17:16];
              8'hC0:   power_nxt     = 1'b1;
              default: unknown_nxt   = 1'b1;
            endcase
          end
          default: unknown_nxt = 1'b1;
        endcase
        // A bit right after the 40th is an overlong frame; the decoded result still goes out.
        if (in_frame_start) begin
          begin_frame = 1'b1;
        end else if (in_bit_valid) begin
          ferr_nxt  = 1'b1;
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        begin_frame = in_frame_start;
      end
    endcase

    // Start wins over a coincident bit strobe: that bit becomes bit 39 of the new frame.
    if (begin_frame) begin
      state_nxt = SHIFT;
      cnt_nxt   = '0;
      take_bit  = in_bit_valid;
    end
    if (take_bit) begin
      shift_nxt = {shift_q[FRAME_BITS-2:0], in_bit};
      cnt_nxt   = begin_frame ? CW'(1) : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      shift_q            <= '0;
      audio_sample       <= '0;
      audio_sample_valid <= 1'b0;
      audio_enabled      <= 1'b0;
      audio_mode         <= '0;
      kbd_query          <= 1'b0;
      led_state          <= '0;
      power_request      <= 1'b0;
      unknown_op         <= 1'b0;
      frame_error        <= 1'b0;
    end else begin
      state_q            <= state_nxt;
      cnt_q              <= cnt_nxt;
      shift_q            <= shift_nxt;
      audio_sample       <= sample_nxt;
      audio_sample_valid <= sample_valid_nxt;
      audio_enabled      <= enabled_nxt;
      audio_mode         <= mode_nxt;
      kbd_query          <= kbd_query_nxt;
      led_state          <= led_nxt;
      power_request      <= power_nxt;
      unknown_op         <= unknown_nxt;
      frame_error        <= ferr_nxt;
    end
  end

endmodule

// File: tb/tb_op_decoder.sv
// Directed bench for op_decoder: hand-computed expectations checked with
// immediate assertions; inputs driven and outputs sampled on the falling edge.
module tb_op_decoder;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        in_frame_start, in_bit, in_bit_valid;
  logic [31:0] audio_sample;
  logic        audio_sample_valid, audio_enabled;
  logic [7:0]  audio_mode;
  logic        kbd_query, power_request, unknown_op, frame_error;
  logic [1:0]  led_state;

  int tests = 0;
  int fails = 0;

  logic [4:0] pulses;
  assign pulses = {audio_sample_valid, kbd_query, power_request, unknown_op, frame_error};

  always #5 clk = ~clk;

  op_decoder dut (
    .clk                (clk),
    .n_reset            (n_reset),
    .in_frame_start     (in_frame_start),
    .in_bit             (in_bit),
    .in_bit_valid       (in_bit_valid),
    .audio_sample       (audio_sample),
    .audio_sample_valid (audio_sample_valid),
    .audio_enabled      (audio_enabled),
    .audio_mode         (audio_mode),
    .kbd_query          (kbd_query),
    .led_state          (led_state),
    .power_request      (power_request),
    .unknown_op         (unknown_op),
    .frame_error        (frame_error)
  );

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_frame_start = 1'b0;
    in_bit_valid   = 1'b0;
    in_bit         = 1'b0;
  endtask

  task automatic send_start();
    @(negedge clk);
    in_frame_start = 1'b1;
    in_bit_valid   = 1'b0;
  endtask

  task automatic send_bits(input logic [39:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_frame_start = 1'b0;
      in_bit_valid   = 1'b1;
      in_bit         = d[39-i];
    end
  endtask

  // Full packet; returns at the falling edge where the decode pulse should be visible.
  task automatic send_packet(input logic [39:0] d, input string tag);
    send_start();
    send_bits(d, 40);
    idle();
    check({tag, "_no_early_pulse"}, {35'd0, pulses}, 40'd0);
    idle();
  endtask

  initial begin
    n_reset        = 1'b0;
    in_frame_start = 1'b0;
    in_bit         = 1'b0;
    in_bit_valid   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_sample", {8'd0, audio_sample}, 40'd0);
    check("reset_levels", {29'd0, audio_enabled, audio_mode, led_state}, 40'd0);
    check("reset_pulses", {35'd0, pulses}, 40'd0);
    n_reset = 1'b1;
    idle();

    send_packet(40'h07_1234_ABCD, "sample1");
    check("sample1_valid", {35'd0, pulses}, {35'd0, 5'b10000});
    check("sample1_data", {8'd0, audio_sample}, {8'd0, 32'h1234_ABCD});
    idle();
    check("sample1_one_cycle", {35'd0, pulses}, 40'd0);

    send_packet(40'hC7_01_000000, "actrl_on");
    check("actrl_on_state", {31'd0, audio_enabled, audio_mode}, {31'd0, 1'b1, 8'h01});
    check("actrl_on_pulses", {35'd0, pulses}, 40'd0);
    send_packet(40'hC7_00_000000, "actrl_off");
    check("actrl_off_state", {31'd0, audio_enabled, audio_mode}, 40'd0);

    send_packet(40'hC5_EF_000000, "kbdq");
    check("kbdq_pulse", {35'd0, pulses}, {35'd0, 5'b01000});
    idle();
    check("kbdq_one_cycle", {35'd0, pulses}, 40'd0);

    send_packet(40'hC5_00_030000, "led3");
    check("led3_state", {38'd0, led_state}, {38'd0, 2'b11});
    check("led3_no_pulse", {35'd0, pulses}, 40'd0);

    send_packet(40'hC5_C0_000000, "pwr");
    check("pwr_pulse", {35'd0, pulses}, {35'd0, 5'b00100});

    send_packet(40'hC5_12_000000, "kbd_bad_sub");
    check("kbd_bad_sub_unknown", {35'd0, pulses}, {35'd0, 5'b00010});

    // Truncated frame: 20 bits, then a fresh start.
    send_start();
    send_bits(40'hFF_FFFF_FFFF, 20);
    send_start();
    idle();
    check("trunc_ferr", {35'd0, pulses}, {35'd0, 5'b00001});
    idle();
    check("trunc_ferr_one_cycle", {35'd0, pulses}, 40'd0);
    send_bits(40'h07_0000_0001, 40);
    idle();
    idle();
    check("trunc_next_valid", {35'd0, pulses}, {35'd0, 5'b10000});
    check("trunc_next_data", {8'd0, audio_sample}, 40'h00_0000_0001);

    // Overlong frame: unknown op, then one extra bit during DECODE.
    send_start();
    send_bits(40'h55_0000_0000, 40);
    send_bits(40'h80_0000_0000, 1);
    check("long_no_early", {35'd0, pulses}, 40'd0);
    idle();
    check("long_unknown_and_ferr", {35'd0, pulses}, {35'd0, 5'b00011});
    send_bits(40'h07_FFFF_FFFF, 40);
    idle();
    idle();
    check("discard_no_pulse", {35'd0, pulses}, 40'd0);
    check("discard_sample_held", {8'd0, audio_sample}, 40'h00_0000_0001);

    // Start + valid in the same cycle: that bit is bit 39 of the frame.
    @(negedge clk);
    in_frame_start = 1'b1;
    in_bit_valid   = 1'b1;
    in_bit         = 1'b0;
    send_bits(40'h07_00BE_EF42 << 1, 39);
    idle();
    idle();
    check("same_cycle_valid", {35'd0, pulses}, {35'd0, 5'b10000});
    check("same_cycle_data", {8'd0, audio_sample}, 40'h00_00BE_EF42);

    send_packet(40'hC5_00_010000, "led1");
    check("led1_state", {38'd0, led_state}, 40'd1);
    send_packet(40'hC7_5A_000000, "actrl_5a");
    check("actrl_5a_state", {31'd0, audio_enabled, audio_mode}, {31'd0, 1'b1, 8'h5A});

    // Reset in the middle of a packet.
    send_start();
    send_bits(40'hC5_EF_0000_00, 30);
    @(negedge clk);
    in_bit_valid = 1'b0;
    n_reset      = 1'b0;
    #1;
    check("midrst_sample", {8'd0, audio_sample}, 40'd0);
    check("midrst_levels", {29'd0, audio_enabled, audio_mode, led_state}, 40'd0);
    check("midrst_pulses", {35'd0, pulses}, 40'd0);
    @(negedge clk);
    n_reset = 1'b1;
    idle();
    send_packet(40'h07_CAFE_F00D, "post_rst");
    check("post_rst_valid", {35'd0, pulses}, {35'd0, 5'b10000});
    check("post_rst_data", {8'd0, audio_sample}, {8'd0, 32'hCAFE_F00D});

    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
